timer_counter: RTL and testbench

//   64-bit up-counter with power-of-two prescaler; downstream consumer of the timer

---
 rtl/timer_counter.sv | 107 ++++++++++
 tb/tb_timer_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// 64-bit up-counter with power-of-two prescaler, debug halt and byte-strobed writes.
// Optional wrap-detect pulse on ovf_pulse when TIMER_CNT_OVF_EN is defined.
module timer_counter #(
    parameter int DIV_MAX = 8,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        stop,
    input  logic        wr_dr0,
    input  logic        wr_dr1,
    input  logic [31:0] wdata,
    input  logic [3:0]  pstrb,
    output logic [63:0] count,
    output logic        cnt_tick,
    output logic        ovf_pulse
);
    localparam logic [3:0] DIV_MAX_L = 4'(DIV_MAX);

    logic [63:0]        count_reg, count_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [3:0]         div_val_q;
    logic               cnt_tick_reg;

    logic [3:0]         eff_k;
    logic [PRESC_W-1:0] presc_top;
    logic               active, div_chg, wr_any, use_presc, inc_fire, inc;
    logic [31:0]        lo_wr, hi_wr;

    always_comb begin
        eff_k     = (div_val > DIV_MAX_L) ? DIV_MAX_L : div_val;
        // Terminal prescaler value 2^k-1 without a wider intermediate.
        presc_top = ~({PRESC_W{1'b1}} << eff_k);
        use_presc = div_en && (eff_k != 4'd0);
        active    = timer_en && !stop;
        div_chg   = (div_val != div_val_q);
        wr_any    = wr_dr0 || wr_dr1;
        inc_fire  = active && (!use_presc || (presc_reg == presc_top));
        inc       = inc_fire && !div_chg && !wr_any;
    end

    always_comb begin
        presc_next = presc_reg;
        if (!timer_en || !use_presc || div_chg) begin
            presc_next = '0;
        end else if (!stop) begin
            presc_next = (presc_reg == presc_top) ? '0 : presc_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lo_wr[8*gi +: 8] = (wr_dr0 && pstrb[gi]) ? wdata[8*gi +: 8]
                                                            : count_reg[8*gi +: 8];
            assign hi_wr[8*gi +: 8] = (wr_dr1 && pstrb[gi]) ? wdata[8*gi +: 8]
                                                            : count_reg[32 + 8*gi +: 8];
        end
    endgenerate

    // A software write wins over the increment for the full 64 bits.
    always_comb begin
        count_next = count_reg;
        if (wr_any) begin
            count_next = {hi_wr, lo_wr};
        end else if (inc) begin
            count_next = count_reg + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            presc_reg    <= '0;
            div_val_q    <= '0;
            cnt_tick_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            presc_reg    <= presc_next;
            div_val_q    <= div_val;
            cnt_tick_reg <= inc;
        end
    end

`ifdef TIMER_CNT_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= inc && (&count_reg);
        end
    end

    assign ovf_pulse = ovf_reg;
`else
    assign ovf_pulse = 1'b0;
`endif

    assign count    = count_reg;
    assign cnt_tick = cnt_tick_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// stimulus compared each cycle against a period/phase reference model.
module tb_timer_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timer_en = 1'b0;
    logic        div_en = 1'b0;
    logic [3:0]  div_val = 4'd0;
    logic        stop = 1'b0;
    logic        wr_dr0 = 1'b0;
    logic        wr_dr1 = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  pstrb = 4'd0;
    logic [63:0] count;
    logic        cnt_tick;
    logic        ovf_pulse;

    timer_counter dut (
        .clk(clk), .rst_n(rst_n), .timer_en(timer_en), .div_en(div_en),
        .div_val(div_val), .stop(stop), .wr_dr0(wr_dr0), .wr_dr1(wr_dr1),
        .wdata(wdata), .pstrb(pstrb), .count(count), .cnt_tick(cnt_tick),
        .ovf_pulse(ovf_pulse)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_step  = 0;

    // Reference model: count, position within the current prescale period,
    // and the last div_val seen (for change detection).
    logic [63:0] m_count;
    int          m_phase;
    logic [3:0]  m_prev_dv;
    logic        m_tick;
    logic        m_ovf;

`ifdef TIMER_CNT_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (step %0d)", tag, got, exp, n_step);
        end
    endtask

    task automatic model_reset();
        m_count   = '0;
        m_phase   = 0;
        m_prev_dv = 4'd0;
        m_tick    = 1'b0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_clock(input logic en, input logic de, input logic [3:0] dv,
                               input logic st, input logic w0, input logic w1,
                               input logic [31:0] wd, input logic [3:0] ps);
        int   k, period;
        logic chg, fire, inc;
        logic [63:0] nxt;
        chg    = (dv != m_prev_dv);
        k      = (int'(dv) > 8) ? 8 : int'(dv);
        period = (de && k != 0) ? (1 << k) : 1;
        fire   = en && !st && (period == 1 || m_phase == period - 1);
        inc    = fire && !chg && !(w0 || w1);
        nxt    = m_count;
        if (w0 || w1) begin
            for (int i = 0; i < 4; i++) begin
                if (w0 && ps[i]) nxt[8*i +: 8]      = wd[8*i +: 8];
                if (w1 && ps[i]) nxt[32 + 8*i +: 8] = wd[8*i +: 8];
            end
        end else if (inc) begin
            nxt = m_count + 64'd1;
        end
        m_ovf  = OVF_ON && inc && (m_count == {64{1'b1}});
        m_tick = inc;
        if (!en || !de || chg || period == 1) m_phase = 0;
        else if (!st) m_phase = (m_phase + 1) % period;
        m_count   = nxt;
        m_prev_dv = dv;
    endtask

    task automatic step(input logic en, input logic de, input logic [3:0] dv,
                        input logic st, input logic w0, input logic w1,
                        input logic [31:0] wd, input logic [3:0] ps);
        timer_en = en; div_en = de; div_val = dv; stop = st;
        wr_dr0 = w0; wr_dr1 = w1; wdata = wd; pstrb = ps;
        @(posedge clk);
        model_clock(en, de, dv, st, w0, w1, wd, ps);
        #1;
        n_step++;
        $display("step %0d en=%b de=%b dv=%0d st=%b w=%b%b count=%h tick=%b ovf=%b",
                 n_step, en, de, dv, st, w1, w0, count, cnt_tick, ovf_pulse);
        check("count", count, m_count);
        check("cnt_tick", {63'd0, cnt_tick}, {63'd0, m_tick});
        check("ovf_pulse", {63'd0, ovf_pulse}, {63'd0, m_ovf});
    endtask

    task automatic run(input int n, input logic de, input logic [3:0] dv);
        for (int i = 0; i < n; i++) step(1'b1, de, dv, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_count", count, 64'd0);
        check("rst_tick", {63'd0, cnt_tick}, 64'd0);
        check("rst_ovf", {63'd0, ovf_pulse}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] base;
        model_reset();
        #2;
        check("rst_count", count, 64'd0);
        check("rst_tick", {63'd0, cnt_tick}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Undivided counting: 10 cycles -> 10
        run(10, 1'b0, 4'd0);
        check("t1_count10", count, 64'd10);

        // div_val=2: one change cycle, then 16 active cycles -> +4
        base = m_count;
        run(1, 1'b1, 4'd2);
        check("t2_chg_no_inc", count, base);
        run(16, 1'b1, 4'd2);
        check("t2_div4", count, base + 64'd4);

        // div_val=9 clamps to 256-cycle period
        base = m_count;
        run(1, 1'b1, 4'd9);
        run(255, 1'b1, 4'd9);
        check("t2_div256_early", count, base);
        run(1, 1'b1, 4'd9);
        check("t2_div256", count, base + 64'd1);

        // Carry from low half into high half
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 4'hF);
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'hF);
        check("t3_loaded", count, 64'h0000_0000_FFFF_FFFE);
        run(2, 1'b0, 4'd9);
        check("t3_carry", count, 64'h0000_0001_0000_0000);

        // Byte-strobed high-half write, increment suppressed
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 4'hF);
        step(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101);
        check("t4_strobe", count, 64'h00BB_00DD_0000_0000);
        check("t4_no_tick", {63'd0, cnt_tick}, 64'd0);

        // Debug halt mid-period freezes count and prescaler phase
        run(1, 1'b1, 4'd2);
        run(6, 1'b1, 4'd2);
        base = m_count;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0);
            check("t5_frozen", count, base);
        end
        run(1, 1'b1, 4'd2);
        check("t5_resume_phase", count, base);
        run(1, 1'b1, 4'd2);
        check("t5_resume_inc", count, base + 64'd1);

        // Wrap from all-ones
        step(1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF);
        check("t6_ones", count, {64{1'b1}});
        check("t6_wr_no_ovf", {63'd0, ovf_pulse}, 64'd0);
        run(1, 1'b0, 4'd2);
        check("t6_wrap", count, 64'd0);
        check("t6_ovf", {63'd0, ovf_pulse}, {63'd0, OVF_ON});
        run(1, 1'b0, 4'd2);
        check("t6_ovf_one_cycle", {63'd0, ovf_pulse}, 64'd0);

        // Reset asserted mid-count
        run(3, 1'b0, 4'd0);
        async_reset();

        // Randomized traffic
        begin
            logic [3:0] dv_r;
            dv_r = 4'd1;
            for (int i = 0; i < 600; i++) begin
                logic en_r, de_r, st_r, w0_r, w1_r;
                logic [31:0] wd_r;
                if ($urandom_range(0, 19) == 0)
                    dv_r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, 3));
                en_r = ($urandom_range(0, 7) != 0);
                de_r = ($urandom_range(0, 3) != 0);
                st_r = ($urandom_range(0, 7) == 0);
                w0_r = ($urandom_range(0, 15) == 0);
                w1_r = ($urandom_range(0, 15) == 0);
                wd_r = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                step(en_r, de_r, dv_r, st_r, w0_r, w1_r, wd_r, 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 199) == 0) async_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
